sopc_data_bus: RTL
==================

Name: sopc_data_bus

Overview:
- Parametrised data-side system bus for the next-generation SOPC top.
- Replaces the direct CPU-to-data_ram connection with an address-decoded fabric of NUM_SLAVES slaves (RAM, timer, UART, GPIO, ...).
- Each slave is variable-latency with an ack handshake; the CPU is stalled until completion.
- Decode errors and timeouts are reported to the CPU and raise a sticky error interrupt that feeds one int_i bit.

Parameters:
- DATA_W, 32, data width; multiple of 8.
- ADDR_W, 32, address width.
- NUM_SLAVES, 4, number of slave ports, 1..2^SEL_W.
- SEL_W, 2, slave index = m_addr_i[ADDR_W-1 -: SEL_W].
- TIMEOUT, 16, max cycles in ACCESS without ack before error; >=1.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- m_ce_i  in  1  CPU data request; held stable while m_stall_o=1.
- m_we_i  in  1  1=write, 0=read.
- m_addr_i  in  ADDR_W  byte address.
- m_sel_i  in  DATA_W/8  byte enables.
- m_data_i  in  DATA_W  write data.
- m_data_o  out  DATA_W  read data; valid in DONE.
- m_stall_o  out  1  CPU stall.
- m_err_o  out  1  one-cycle bus-error pulse to CPU.
- s_ce_o  out  NUM_SLAVES  one-hot slave select.
- s_we_o  out  1  shared write enable.
- s_addr_o  out  ADDR_W  shared address.
- s_sel_o  out  DATA_W/8  shared byte enables.
- s_data_o  out  DATA_W  shared write data.
- s_data_i  in  NUM_SLAVES*DATA_W  slave read data; slave i at bits [i*DATA_W +: DATA_W].
- s_ack_i  in  NUM_SLAVES  per-slave completion.
- err_int_o  out  1  sticky error interrupt level.
- err_addr_o  out  ADDR_W  address of the last failed access.
- err_clr_i  in  1  clears err_int_o.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE. All outputs 0, including s_ce_o, m_stall_o, m_err_o, err_int_o and err_addr_o. The timeout counter is 0.
  - Reset mid-transaction aborts the transaction; s_ce_o drops immediately.
- FSM states: IDLE, ACCESS, DONE, ERR.
- IDLE:
  - m_stall_o = m_ce_i (combinational).
  - On m_ce_i=1, latch we/addr/sel/data and idx.
  - idx < NUM_SLAVES -> ACCESS; otherwise -> ERR (decode error).
- ACCESS:
  - s_ce_o[idx]=1 and shared s_* outputs come from registered latches.
  - m_stall_o=1.
  - Counter increments every cycle.
  - s_ack_i[idx]=1 -> capture s_data_i slice idx (reads only; writes capture 0) and go to DONE.
  - Else if counter == TIMEOUT-1 -> ERR.
  - If ack and timeout coincide, ack wins.
  - Acks from non-selected slaves are ignored.
- DONE (1 cycle):
  - s_ce_o=0, m_stall_o=0, m_data_o=captured data.
  - m_ce_i is ignored; next state is IDLE.
- ERR (1 cycle):
  - s_ce_o=0, m_stall_o=0, m_data_o=0, m_err_o=1.
  - err_addr_o <= latched address; err_int_o set -> IDLE.
- m_data_o is 0 outside DONE.
- Minimum latency, request to stall release: request cycle + 1 ACCESS cycle, then DONE. Total 3 cycles per access; back-to-back requests resume in the cycle after DONE.
- Latched request fields are frozen from IDLE acceptance until IDLE is re-entered; changes on m_* during ACCESS have no effect.
- err_int_o:
  - Set by ERR entry and held.
  - Cleared by err_clr_i=1 on a clock edge.
  - A set and a clear in the same cycle: set wins.
- err_addr_o is overwritten by each new error.

Test Plan:
- Read, zero-wait: slave 1 acks in the first ACCESS cycle with s_data_i slice 1=32'hDEADBEEF; m_addr_i=32'h4000_0010 -> s_ce_o=4'b0010 for exactly 1 cycle; m_stall_o high 2 cycles; DONE m_data_o=32'hDEADBEEF.
- Write, 3 wait states: m_addr_i=32'h0000_0004, m_sel_i=4'b0011, m_data_i=32'h1234_5678; slave 0 acks on the 4th ACCESS cycle -> s_sel_o=4'b0011, s_data_o=32'h1234_5678 held 4 cycles; stall 5 cycles; m_err_o=0.
- Decode error: NUM_SLAVES=3, m_addr_i=32'hC000_0000 -> no s_ce_o bit ever set; ERR next cycle with m_err_o=1; err_int_o=1; err_addr_o=32'hC000_0000.
- Timeout and clear:
  - TIMEOUT=16, slave 2 never acks -> exactly 16 ACCESS cycles, then m_err_o pulse.
  - err_clr_i pulse -> err_int_o=0.
  - err_clr_i coinciding with a new ERR -> err_int_o stays 1.
- Ack/timeout coincidence and stray ack: ack on ACCESS cycle 16 -> DONE, no error. s_ack_i from a non-selected slave -> ignored, transaction continues.
- Async reset mid-ACCESS: rst low between clock edges -> s_ce_o and m_stall_o drop immediately. After rst high, first request completes normally.

Source files
------------

// File: rtl/sopc_data_bus.sv
// sopc_data_bus: address-decoded data-side bus between the CPU and
// NUM_SLAVES variable-latency slaves. The CPU is stalled while a slave
// access is in flight. Decode errors and ack timeouts return a one-cycle
// error pulse and raise a sticky interrupt with the failing address.
module sopc_data_bus #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 32,
  parameter int NUM_SLAVES = 4,
  parameter int SEL_W      = 2,
  parameter int TIMEOUT    = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         m_ce_i,
  input  logic                         m_we_i,
  input  logic [ADDR_W-1:0]            m_addr_i,
  input  logic [DATA_W/8-1:0]          m_sel_i,
  input  logic [DATA_W-1:0]            m_data_i,
  output logic [DATA_W-1:0]            m_data_o,
  output logic                         m_stall_o,
  output logic                         m_err_o,
  output logic [NUM_SLAVES-1:0]        s_ce_o,
  output logic                         s_we_o,
  output logic [ADDR_W-1:0]            s_addr_o,
  output logic [DATA_W/8-1:0]          s_sel_o,
  output logic [DATA_W-1:0]            s_data_o,
  input  logic [NUM_SLAVES*DATA_W-1:0] s_data_i,
  input  logic [NUM_SLAVES-1:0]        s_ack_i,
  output logic                         err_int_o,
  output logic [ADDR_W-1:0]            err_addr_o,
  input  logic                         err_clr_i
);

  localparam int BE_W  = DATA_W / 8;
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  // One extra bit so the compare also works when every index is populated.
  localparam logic [SEL_W:0]   NUM_S    = (SEL_W + 1)'(NUM_SLAVES);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2,
    ERR    = 2'd3
  } state_t;

  state_t              state_q;
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [BE_W-1:0]     sel_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [SEL_W-1:0]    idx_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                err_int_q;
  logic [ADDR_W-1:0]   err_addr_q;

  logic                in_access;
  logic [SEL_W-1:0]    req_idx;
  logic [DATA_W-1:0]   slave_rdata [NUM_SLAVES];
  logic [DATA_W-1:0]   sel_rdata;
  logic                sel_ack;

  assign in_access = (state_q == ACCESS);
  assign req_idx   = m_addr_i[ADDR_W-1 -: SEL_W];

  // Per-slave read-data slices and one-hot chip enables.
  generate
    for (genvar gi = 0; gi < NUM_SLAVES; gi++) begin : g_slave
      assign slave_rdata[gi] = s_data_i[gi*DATA_W +: DATA_W];
      assign s_ce_o[gi]      = in_access && (idx_q == SEL_W'(gi));
    end
  endgenerate

  // Pick the ack and read data of the addressed slave; others are ignored.
  always_comb begin
    sel_rdata = '0;
    sel_ack   = 1'b0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (idx_q == SEL_W'(i)) begin
        sel_rdata = slave_rdata[i];
        sel_ack   = s_ack_i[i];
      end
    end
  end

  // Shared slave outputs only carry the latched request during ACCESS.
  assign s_we_o   = in_access & we_q;
  assign s_addr_o = in_access ? addr_q  : '0;
  assign s_sel_o  = in_access ? sel_q   : '0;
  assign s_data_o = in_access ? wdata_q : '0;

  // CPU side: stall follows the request in IDLE so the request cycle
  // itself is stalled; reset forces it low immediately.
  always_comb begin
    m_stall_o = 1'b0;
    case (state_q)
      IDLE:    m_stall_o = rst & m_ce_i;
      ACCESS:  m_stall_o = 1'b1;
      default: m_stall_o = 1'b0;
    endcase
  end

  assign m_data_o   = (state_q == DONE) ? rdata_q : '0;
  assign m_err_o    = (state_q == ERR);
  assign err_int_o  = err_int_q;
  assign err_addr_o = err_addr_q;

  // Bus FSM with request latches, timeout counter and sticky error state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      we_q       <= 1'b0;
      addr_q     <= '0;
      sel_q      <= '0;
      wdata_q    <= '0;
      idx_q      <= '0;
      cnt_q      <= '0;
      rdata_q    <= '0;
      err_int_q  <= 1'b0;
      err_addr_q <= '0;
    end else begin
      // A clear is overridden below when an error is raised on this edge.
      if (err_clr_i) begin
        err_int_q <= 1'b0;
      end
      case (state_q)
        IDLE: begin
          if (m_ce_i) begin
            we_q    <= m_we_i;
            addr_q  <= m_addr_i;
            sel_q   <= m_sel_i;
            wdata_q <= m_data_i;
            idx_q   <= req_idx;
            cnt_q   <= '0;
            if ({1'b0, req_idx} < NUM_S) begin
              state_q <= ACCESS;
            end else begin
              state_q    <= ERR;
              err_int_q  <= 1'b1;
              err_addr_q <= m_addr_i;
            end
          end
        end
        ACCESS: begin
          if (sel_ack) begin
            rdata_q <= we_q ? '0 : sel_rdata;
            cnt_q   <= '0;
            state_q <= DONE;
          end else if (cnt_q == CNT_LAST) begin
            cnt_q      <= '0;
            state_q    <= ERR;
            err_int_q  <= 1'b1;
            err_addr_q <= addr_q;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        ERR: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule
